// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
// Holds the two-state sequencer enum, the bundled stage-control struct
// and the canonical NOP (addi x0,x0,0) loaded by flushed registers.
package pipeline_ctrl_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic {
    RUN     = 1'b0,
    REFETCH = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctl_t;

  // Free-running pipeline: everything loads, nothing flushed.
  localparam pipe_ctl_t CTL_ADVANCE = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                        id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                        ex_mem_en: 1'b1, mem_wb_en: 1'b1};
  // Full freeze: no register loads.
  localparam pipe_ctl_t CTL_FREEZE  = '0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Ports: clock, reset_n (async clear), inc_i (count enable), cnt_o (value).
// Holds at all-ones once reached; clears immediately when reset_n falls.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Inputs: ID source regs/use flags, EX dest/load flag, EX branch outcome,
//   imem/dmem handshakes. Outputs: per-stage load enables and flushes,
//   refetch debug flag, saturating stall and redirect counters.
// Controls are combinational from state+inputs; only state/counters register.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  refetch,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  import pipeline_ctrl_pkg::*;

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  pipe_ctl_t   ctl;
  logic        dbusy;
  logic        lu;
  logic        flush_inc;

  assign dbusy = dmem_req & ~dmem_ready;
  assign lu    = ex_mem_read & (ex_rd != '0) &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    ctl       = CTL_ADVANCE;
    state_d   = state_q;
    flush_inc = 1'b0;
    if (!reset_n) begin
      ctl = CTL_FREEZE;
    end else if (dbusy) begin
      // Freeze everything; inputs are re-evaluated once dmem completes.
      ctl = CTL_FREEZE;
    end else if (ex_branch_taken) begin
      // PC loads the target; squash the two wrong-path instructions.
      ctl.if_id_flush = 1'b1;
      ctl.id_ex_flush = 1'b1;
      state_d         = REFETCH;
      flush_inc       = 1'b1;
    end else if (state_q == RUN) begin
      if (lu) begin
        ctl.pc_en       = 1'b0;
        ctl.if_id_en    = 1'b0;
        ctl.id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        ctl.pc_en       = 1'b0;
        ctl.if_id_flush = 1'b1;
      end
    end else begin
      // REFETCH: ID only holds a squashed slot, so only fetch readiness matters.
      if (imem_ready) begin
        state_d = RUN;
      end else begin
        ctl.pc_en       = 1'b0;
        ctl.if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .inc_i  (~ctl.pc_en),
    .cnt_o  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .reset_n(reset_n),
    .inc_i  (flush_inc),
    .cnt_o  (flush_cnt)
  );

  assign pc_en       = ctl.pc_en;
  assign if_id_en    = ctl.if_id_en;
  assign if_id_flush = ctl.if_id_flush;
  assign id_ex_en    = ctl.id_ex_en;
  assign id_ex_flush = ctl.id_ex_flush;
  assign ex_mem_en   = ctl.ex_mem_en;
  assign mem_wb_en   = ctl.mem_wb_en;
  assign refetch     = (state_q == REFETCH);

endmodule
